// File: rtl/spi_flash_pkg.sv
// Shared SPI flash definitions: opcodes and protocol FSM states,
// common to this responder and the ROM-side SPI initiator.
package spi_flash_pkg;

    localparam logic [7:0]  OP_READ      = 8'h03;
    localparam logic [7:0]  OP_FAST_READ = 8'h0B;
    localparam int unsigned DUMMY_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus edge detection on the
// synchronized chip select and clock.
module spi_sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic spi_cs_i,
    input  logic spi_sclk_i,
    input  logic spi_mosi_i,
    output logic cs_o,
    output logic cs_fall_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic mosi_o
);

    logic [1:0] cs_sync_q;
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic       cs_prev_q;
    logic       sclk_prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs_i};
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
            cs_prev_q   <= cs_sync_q[1];
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    assign cs_o        = cs_sync_q[1];
    assign cs_fall_o   = cs_prev_q & ~cs_sync_q[1];
    assign sclk_rise_o = ~sclk_prev_q & sclk_sync_q[1];
    assign sclk_fall_o = sclk_prev_q & ~sclk_sync_q[1];
    assign mosi_o      = mosi_sync_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder (opcode 0x03) fed by a one-byte prefetching
// fetch port. Define FAST_READ_EN to also accept 0x0B with 8 dummy clocks.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter logic        MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned      CNT_W     = $clog2(ADDR_W) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);

    logic cs_sync;
    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_sync;

    spi_sync_edge u_sync (
        .clk_i       (clk),
        .reset_i     (reset),
        .spi_cs_i    (spi_cs),
        .spi_sclk_i  (spi_sclk),
        .spi_mosi_i  (spi_mosi),
        .cs_o        (cs_sync),
        .cs_fall_o   (cs_fall),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .mosi_o      (mosi_sync)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [ADDR_W-2:0] rx_q, rx_d;
    logic [6:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]        pf_q, pf_d;
    logic              pf_valid_q, pf_valid_d;
    logic              discard_q, discard_d;
    logic              underrun_q, underrun_d;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
`ifdef FAST_READ_EN
    logic              fast_q, fast_d;
`endif

    logic [ADDR_W-1:0] rx_next;
    logic              fetch_trig;
    logic [ADDR_W-1:0] fetch_addr;
    logic              abort;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= MISO_IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pf_q        <= '0;
            pf_valid_q  <= 1'b0;
            discard_q   <= 1'b0;
            underrun_q  <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
`ifdef FAST_READ_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pf_q        <= pf_d;
            pf_valid_q  <= pf_valid_d;
            discard_q   <= discard_d;
            underrun_q  <= underrun_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
`ifdef FAST_READ_EN
            fast_q      <= fast_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        req_d       = req_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pf_d        = pf_q;
        pf_valid_d  = pf_valid_q;
        discard_d   = discard_q;
        underrun_d  = underrun_q;
        settle_d    = settle_q;
        armed_d     = armed_q;
`ifdef FAST_READ_EN
        fast_d      = fast_q;
`endif
        rx_next     = {rx_q, mosi_sync};
        fetch_trig  = 1'b0;
        fetch_addr  = addr_q;
        abort       = 1'b0;

        // Commands are only accepted once the synchronizers have settled and
        // cs has been seen high, so a reset mid-transaction cannot start one.
        if (settle_q != 2'd3) begin
            settle_d = settle_q + 2'd1;
        end else if (cs_sync) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                miso_d = MISO_IDLE;
                if (armed_q && cs_fall) begin
                    state_d    = CMD;
                    bitcnt_d   = '0;
                    underrun_d = 1'b0;
                    pf_valid_d = 1'b0;
`ifdef FAST_READ_EN
                    fast_d     = 1'b0;
`endif
                end
            end

            CMD: begin
                if (cs_sync) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    rx_d     = rx_next[ADDR_W-2:0];
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == BYTE_LAST) begin
                        bitcnt_d = '0;
                        if (rx_next[7:0] == OP_READ) begin
                            state_d = ADDR;
`ifdef FAST_READ_EN
                        end else if (rx_next[7:0] == OP_FAST_READ) begin
                            state_d = ADDR;
                            fast_d  = 1'b1;
`endif
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
            end

            ADDR: begin
                if (cs_sync) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    rx_d     = rx_next[ADDR_W-2:0];
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == ADDR_LAST) begin
                        bitcnt_d   = '0;
                        fetch_trig = 1'b1;
                        fetch_addr = rx_next;
                        state_d    = DATA;
`ifdef FAST_READ_EN
                        if (fast_q) begin
                            state_d = DUMMY;
                        end
`endif
                    end
                end
            end

`ifdef FAST_READ_EN
            DUMMY: begin
                if (cs_sync) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                        bitcnt_d = '0;
                        state_d  = DATA;
                    end
                end
            end
`endif

            DATA: begin
                if (cs_sync) begin
                    abort = 1'b1;
                end else if (sclk_fall) begin
                    bitcnt_d = (bitcnt_q == BYTE_LAST) ? '0 : bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == '0) begin
                        // Byte boundary: an empty buffer means the fetch is late;
                        // that fetch stays in flight and feeds the next byte.
                        if (pf_valid_q) begin
                            miso_d     = pf_q[7];
                            tx_d       = pf_q[6:0];
                            pf_valid_d = 1'b0;
                            fetch_trig = 1'b1;
                            fetch_addr = addr_q + ADDR_W'(1);
                        end else begin
                            miso_d     = 1'b1;
                            tx_d       = '1;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        miso_d = tx_q[6];
                        tx_d   = {tx_q[5:0], 1'b1};
                    end
                end
            end

            IGNORE: begin
                miso_d = MISO_IDLE;
                if (cs_sync) begin
                    abort = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            miso_d     = MISO_IDLE;
            pf_valid_d = 1'b0;
            pend_d     = 1'b0;
            if (req_q && !mem_ack) begin
                discard_d = 1'b1;
            end
        end

        // A fetch left over from an aborted transaction finishes its handshake
        // but its data never reaches the buffer.
        if (req_q && mem_ack) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
            if (!discard_q && !abort) begin
                pf_d       = mem_rdata;
                pf_valid_d = 1'b1;
            end
        end

        issue_valid = fetch_trig | (pend_q & ~abort);
        issue_addr  = fetch_trig ? fetch_addr : pend_addr_q;
        if (issue_valid && !req_q) begin
            req_d  = 1'b1;
            addr_d = issue_addr;
            pend_d = 1'b0;
        end else if (fetch_trig) begin
            pend_d      = 1'b1;
            pend_addr_d = fetch_addr;
        end
    end

    assign spi_miso = miso_q;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign busy     = ~cs_sync;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: directed SPI transactions push
// expected miso bytes and fetch addresses; monitors pop and compare.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W    = 24;
    localparam logic        MISO_IDLE = 1'b0;
    localparam int          HP        = 8;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              spi_cs    = 1'b1;
    logic              spi_sclk  = 1'b0;
    logic              spi_mosi  = 1'b0;
    logic              mem_ack   = 1'b0;
    logic [7:0]        mem_rdata = '0;
    logic              spi_miso;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              busy;
    logic              underrun;

    spi_flash_responder #(
        .ADDR_W    (ADDR_W),
        .MISO_IDLE (MISO_IDLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int unsigned ack_delay = 1;
    int req_count = 0;
    int req_base = 0;
    int idle_bad = 0;
    logic collect = 1'b0;
    logic idle_watch = 1'b0;
    logic [7:0] exp_bytes[$];
    logic [ADDR_W-1:0] exp_addrs[$];
    logic [7:0] mon_sh = '0;
    int mon_n = 0;
    logic [ADDR_W-1:0] mem_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // miso byte monitor: the master samples on sclk rising edges
    initial begin
        forever begin
            @(posedge spi_sclk);
            if (idle_watch && spi_miso !== MISO_IDLE) idle_bad++;
            if (collect) begin
                mon_sh = {mon_sh[6:0], spi_miso};
                mon_n++;
                if (mon_n == 8) begin
                    mon_n = 0;
                    if (exp_bytes.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL miso_byte: got 0x%02h, no byte expected", mon_sh);
                    end else begin
                        check("miso_byte", {24'h0, mon_sh}, {24'h0, exp_bytes.pop_front()});
                    end
                end
            end else begin
                mon_n = 0;
            end
        end
    end

    // backing store: memory[i] = i[7:0], ack after ack_delay cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                mem_a = mem_addr;
                req_count++;
                if (exp_addrs.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_addr: got 0x%0h, no fetch expected", mem_a);
                end else begin
                    check("mem_addr", {8'h0, mem_a}, {8'h0, exp_addrs.pop_front()});
                end
                repeat (ack_delay) @(posedge clk);
                #1;
                mem_ack   = 1'b1;
                mem_rdata = mem_a[7:0];
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                check("req_drop", {31'h0, mem_req}, 32'h0);
            end
        end
    end

    task automatic half();
        repeat (HP) @(posedge clk);
        #3;
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        half();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            half();
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
        end
    endtask

    // final sclk fall coincides with cs rising
    task automatic data_cycles(input int n);
        spi_mosi = 1'b0;
        for (int i = 0; i < n; i++) begin
            half();
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
            if (i == n - 1) spi_cs = 1'b1;
        end
        repeat (20) @(posedge clk);
        #3;
    endtask

    task automatic cs_high();
        half();
        spi_cs = 1'b1;
        repeat (20) @(posedge clk);
        #3;
    endtask

    task automatic read_txn(input logic [7:0] op, input logic [23:0] a, input int nbytes);
        cs_low();
        send_bits({24'h0, op}, 8);
        send_bits({8'h0, a}, 24);
        collect = 1'b1;
        data_cycles(8 * nbytes);
        collect = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #3;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
        check("rst_miso", {31'h0, spi_miso}, {31'h0, MISO_IDLE});
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #3;

        // plain read from 0x10
        exp_addrs.push_back(24'h000010);
        exp_addrs.push_back(24'h000011);
        exp_addrs.push_back(24'h000012);
        exp_bytes.push_back(8'h10);
        exp_bytes.push_back(8'h11);
        cs_low();
        send_bits(32'h03, 8);
        send_bits(32'h000010, 24);
        check("busy_active", {31'h0, busy}, 32'h1);
        collect = 1'b1;
        data_cycles(16);
        collect = 1'b0;
        check("busy_after", {31'h0, busy}, 32'h0);
        check("miso_after", {31'h0, spi_miso}, {31'h0, MISO_IDLE});
        check("underrun_ok", {31'h0, underrun}, 32'h0);

        // address wrap
        exp_addrs.push_back(24'hFFFFFF);
        exp_addrs.push_back(24'h000000);
        exp_addrs.push_back(24'h000001);
        exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'h00);
        read_txn(8'h03, 24'hFFFFFF, 2);

        // unknown opcode
        idle_bad   = 0;
        req_base   = req_count;
        idle_watch = 1'b1;
        cs_low();
        send_bits(32'h9F, 8);
        send_bits(32'h0, 24);
        check("ign_busy", {31'h0, busy}, 32'h1);
        data_cycles(8);
        idle_watch = 1'b0;
        check("ign_miso_idle", idle_bad, 0);
        check("ign_no_req", req_count - req_base, 0);
        check("ign_busy_after", {31'h0, busy}, 32'h0);

        // late fetch -> underrun byte, late byte used next
        ack_delay = 20;
        exp_addrs.push_back(24'h000040);
        exp_addrs.push_back(24'h000041);
        exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'h40);
        read_txn(8'h03, 24'h000040, 2);
        check("underrun_set", {31'h0, underrun}, 32'h1);
        ack_delay = 1;

        // aborted address phase, then a fresh read
        cs_low();
        check("underrun_clr", {31'h0, underrun}, 32'h0);
        send_bits(32'h03, 8);
        send_bits(32'h000, 12);
        cs_high();
        exp_addrs.push_back(24'h000020);
        exp_addrs.push_back(24'h000021);
        exp_addrs.push_back(24'h000022);
        exp_bytes.push_back(8'h20);
        exp_bytes.push_back(8'h21);
        read_txn(8'h03, 24'h000020, 2);

        // fast read
        idle_bad = 0;
        req_base = req_count;
`ifdef FAST_READ_EN
        exp_addrs.push_back(24'h000004);
        exp_addrs.push_back(24'h000005);
        exp_bytes.push_back(8'h04);
        cs_low();
        send_bits(32'h0B, 8);
        send_bits(32'h000004, 24);
        idle_watch = 1'b1;
        send_bits(32'h0, 8);
        idle_watch = 1'b0;
        collect = 1'b1;
        data_cycles(8);
        collect = 1'b0;
        check("fast_dummy_idle", idle_bad, 0);
        check("fast_req_count", req_count - req_base, 2);
`else
        idle_watch = 1'b1;
        cs_low();
        send_bits(32'h0B, 8);
        send_bits(32'h000004, 24);
        send_bits(32'h0, 8);
        data_cycles(8);
        idle_watch = 1'b0;
        check("fast_ign_idle", idle_bad, 0);
        check("fast_ign_no_req", req_count - req_base, 0);
`endif

        // reset in mid-transaction: command ignored until cs goes high
        cs_low();
        send_bits(32'h0, 4);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        idle_bad   = 0;
        req_base   = req_count;
        idle_watch = 1'b1;
        send_bits(32'h03, 8);
        send_bits(32'h000010, 24);
        data_cycles(8);
        idle_watch = 1'b0;
        check("rstabort_no_req", req_count - req_base, 0);
        check("rstabort_idle", idle_bad, 0);

        // recovery after the aborted transaction
        exp_addrs.push_back(24'h000007);
        exp_addrs.push_back(24'h000008);
        exp_bytes.push_back(8'h07);
        read_txn(8'h03, 24'h000007, 1);

        check("bytes_left", exp_bytes.size(), 0);
        check("addrs_left", exp_addrs.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: width of the flash address received on the wire.
REQ-002 SHALL have parameter MISO_IDLE, default 1'b0: value driven on spi_miso whenever no data bit is being shifted out.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port spi_cs, input, 1: chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_sclk, input, 1: SPI clock, mode 0, asynchronous to clk.
REQ-007 SHALL have port spi_mosi, input, 1: command and address bits, MSB first.
REQ-008 SHALL have port spi_miso, output, 1: read data bits, MSB first.
REQ-009 SHALL have port mem_req, output, 1: byte fetch request to the backing store.
REQ-010 SHALL have port mem_addr, output, ADDR_W: byte address of the current fetch.
REQ-011 SHALL have port mem_ack, input, 1: fetch complete; mem_rdata is valid in the same cycle.
REQ-012 SHALL have port mem_rdata, input, 8: fetched byte.
REQ-013 SHALL have port busy, output, 1: high while spi_cs is seen low.
REQ-014 SHALL have port underrun, output, 1: sticky flag, set when a byte was not ready in time.

Function
REQ-015 SHALL pass spi_cs, spi_sclk and spi_mosi through 2-flop synchronizers, and SHALL detect sclk edges from the synchronized copy; supported when f_sclk <= f_clk/8.
REQ-016 SHALL sample mosi on synchronized sclk rising edges and SHALL update miso on falling edges.
REQ-017 SHALL implement FSM states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- IDLE -> CMD on cs falling.
- CMD: after 8 bits, opcode 0x03 -> ADDR; any other opcode -> IGNORE.
- ADDR: after ADDR_W bits -> DATA.
REQ-018 SHALL leave IGNORE only when cs goes high, and SHALL drive MISO_IDLE while in IGNORE.
REQ-019 SHALL assert mem_req with mem_addr = received address one clk after the last address bit is sampled.
REQ-020 SHALL hold mem_req and mem_addr stable until mem_ack, and SHALL drop mem_req the cycle after mem_ack.
REQ-021 SHALL capture mem_rdata on mem_ack into a one-byte prefetch buffer.
REQ-022 SHALL, in DATA, load the prefetch buffer into the shift register on the falling edge that begins each byte, drive bit 7 onto miso, and immediately request address+1.
REQ-023 SHALL, if the prefetch buffer is empty when a byte must start, shift out 0xFF for that byte and set underrun; the late-arriving byte SHALL then be used for the following byte.
REQ-024 SHALL wrap the address from 2^ADDR_W-1 to 0.
REQ-025 SHALL, on cs rising in any state, return to IDLE within 3 clk and drive MISO_IDLE.
REQ-026 SHALL let an outstanding mem_req complete its handshake after cs rises, and SHALL discard that data.
REQ-027 SHALL clear underrun on the next cs falling edge.
REQ-028 SHALL give cs rising priority over a simultaneous sclk edge.

Reset
REQ-029 SHALL, while reset is high, set: FSM = IDLE; mem_req = 0; mem_addr = 0; spi_miso = MISO_IDLE; busy = 0; underrun = 0; synchronizers to cs = 1, sclk = 0; prefetch buffer empty.
REQ-030 SHALL treat reset during a transaction as an abort: after reset release, wait for cs high before accepting a new command.

Configuration
REQ-031 SHALL, with FAST_READ_EN defined, also accept opcode 0x0B: ADDR -> DUMMY for 8 sclk cycles with miso = MISO_IDLE -> DATA, with the fetch issued at DUMMY entry.
REQ-032 SHALL, without FAST_READ_EN, treat 0x0B as unknown (IGNORE) and contain no DUMMY state logic.

Structure
REQ-033 SHALL take opcode constants (0x03, 0x0B) and the FSM state enum from shared package spi_flash_pkg, shared with the ROM-side SPI initiator.
REQ-034 SHALL place the synchronizer and edge detect in sub-module spi_sync_edge; the FSM and datapath SHALL stay in this module.

Verification
REQ-035 Bench SHALL cover: cs low, 0x03, addr 0x000010, 16 sclk; memory[i] = i -> miso bytes 0x10, 0x11; mem_addr sequence 0x10, 0x11, 0x12.
REQ-036 Bench SHALL cover: addr 0xFFFFFF, 2 bytes read -> data from 0xFFFFFF then 0x000000.
REQ-037 Bench SHALL cover: opcode 0x9F -> miso stays MISO_IDLE, mem_req never asserted, busy high until cs rises.
REQ-038 Bench SHALL cover: mem_ack delayed beyond the first data byte start -> first byte 0xFF, underrun = 1; the next cs falling clears it.
REQ-039 Bench SHALL cover: cs raised after 12 address bits, then a new 0x03 to 0x000020 -> correct data from 0x20, with no stale byte.
REQ-040 Bench SHALL cover, with FAST_READ_EN: 0x0B, addr 0x000004, 8 dummy clocks -> miso byte = memory[4]; without the macro, the same stimulus -> IGNORE behaviour.
